ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset). It is the outbound counterpart of the existing PS/2 keyboard receive path. It sits beside the PS/2 interface on the shared open-drain ps2_clock/ps2_data lines and drives only the output-enables; the top level ties pads low when an enable is asserted. It exposes busy so the receive path can ignore bus activity during a host transmission.

Parameters:
INHIBIT_CYCLES, 5000, clock-low inhibit time (100 us at 50 MHz).
START_TIMEOUT_CYCLES, 750000, max wait for first device falling edge after request (15 ms).
XFER_TIMEOUT_CYCLES, 100000, max time from first device edge to ACK (2 ms).
CNT_W, 20, timer width; must hold the largest parameter.

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
tx_data  in  8  command byte
tx_valid  in  1  request; accepted when tx_valid && tx_ready
tx_ready  out  1  high only in IDLE
busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse: byte sent and ACKed
tx_error  out  1  one-cycle pulse: timeout or NACK
ps2_clk_in  in  1  raw pad value of ps2_clock (asynchronous)
ps2_dat_in  in  1  raw pad value of ps2_data (asynchronous)
ps2_clk_oe  out  1  1 = pull ps2_clock low
ps2_dat_oe  out  1  1 = pull ps2_data low

Behaviour:
- Reset values: tx_ready=1, busy=0, tx_done=0, tx_error=0, ps2_clk_oe=0, ps2_dat_oe=0, state=IDLE, timer=0, bit count=0.
- The block releases both lines immediately on reset assertion, including in the middle of a frame.
- Inputs pass through a 2-FF synchronizer. A device falling edge (fe) is prev=1, cur=0 on the synchronized clock, so detection lags the pad by 3 cycles.
- On acceptance, the block latches the shift register {stop=1, parity, tx_data}. Parity is odd: the inverse of the XOR-reduce of tx_data.
- IDLE: lines released. On accept, go to INHIBIT next cycle. tx_valid outside IDLE is ignored and not queued.
- INHIBIT: clk_oe=1, dat_oe=0, for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: dat_oe=1 (start bit) and clk_oe=0 in the same cycle; the timer restarts.
  - fe → DATA, and the block drives bit0.
  - timer reaches START_TIMEOUT_CYCLES → ERR.
- DATA: on each fe, drive the next bit LSB-first: bits 0–7, then parity, then stop. Drive rule: dat_oe = ~bit.
  - Bit index counts 0–9.
  - The fe that would drive past the stop bit instead releases the line and goes to ACK.
- ACK: on the next fe, sample the synchronized data.
  - 0 → WAIT_IDLE.
  - 1 → ERR (NACK).
- WAIT_IDLE: wait until synchronized clock and data are both 1, then go to DONE.
- DONE: tx_done=1 for one cycle, then IDLE.
- ERR: tx_error=1 for one cycle, lines released, then IDLE.
- XFER timeout: the timer restarts on entry to DATA. Reaching XFER_TIMEOUT_CYCLES in DATA, ACK or WAIT_IDLE → ERR.
- tx_done and tx_error are never asserted together.
- Latency with no waiting on the device: accept → INHIBIT is 1 cycle; INHIBIT → REQ is INHIBIT_CYCLES cycles.

Optional Feature:
PS2_TX_RETRY_EN:
- Defined: the first error (timeout or NACK) does not pulse tx_error. The block returns to INHIBIT with the same latched byte and retries once; only a second failure pulses tx_error. busy stays high throughout.
- Undefined: the first failure pulses tx_error.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE, DONE, ERR);
  - FRAME_BITS=10;
  - command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
- Sub-module ps2_sync_edge: 2-FF synchronizer plus falling-edge detect, instanced for clock and data. The receive path reuses it.

Test Plan:
1. Send 0xED with a device BFM clocking at 12.5 kHz and ACKing. The bench checks:
   - clk_oe high for exactly 5000 cycles;
   - sampled bits 1,0,1,1,0,1,1,1, then parity 1, then stop 1;
   - exactly one tx_done pulse, no tx_error.
2. Parity coverage: 0x00 → parity 1; 0x01 → parity 0; 0xFF → parity 1; each ends in tx_done.
3. Device never clocks → tx_error exactly 5000+750000 cycles after accept (+1 cycle for the state transition); lines released; tx_ready=1.
4. Device NACKs (data high at ACK edge) → tx_error, no tx_done. With PS2_TX_RETRY_EN, expect a second INHIBIT phase; a good retry gives tx_done only.
5. Assert reset mid-DATA at bit 4 → clk_oe=dat_oe=0 in the same cycle. After release: tx_ready=1, and a new 0xF4 send completes.
6. Pulse tx_valid with 0x55 while busy → ignored; the in-flight byte is transmitted unchanged and only one tx_done occurs.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, frame constants and command bytes
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_t;

    localparam int FRAME_BITS = 10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // Frame is sent LSB first: data[7:0], odd parity, stop (always 1).
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~(^data), data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-FF pad synchronizer with falling-edge detect (shared with the receive path)
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic meta;
    logic prev;

    // Idle bus is pulled high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            meta  <= pad;
            level <= meta;
            prev  <= level;
        end
    end

    assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter driving open-drain output enables
// Define PS2_TX_RETRY_EN to retry a failed frame once before reporting tx_error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000,
    parameter int CNT_W                = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_INDEX   = 4'(FRAME_BITS);

    ps2_state_t            state;
    logic [CNT_W-1:0]      timer;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] frame;

    logic clk_s;
    logic clk_fe;
    logic dat_s;
    logic dat_fall_unused;
    logic fail;
    logic retry_ok;

    ps2_sync_edge u_sync_clk (
        .clock (clock),
        .reset (reset),
        .pad   (ps2_clk_in),
        .level (clk_s),
        .fall  (clk_fe)
    );

    ps2_sync_edge u_sync_dat (
        .clock (clock),
        .reset (reset),
        .pad   (ps2_dat_in),
        .level (dat_s),
        .fall  (dat_fall_unused)
    );

`ifdef PS2_TX_RETRY_EN
    logic retried;
    assign retry_ok = ~retried;
`else
    assign retry_ok = 1'b0;
`endif

    // A device event in the same cycle as a timeout wins; a high data line on the ACK edge is a NACK.
    always_comb begin
        fail = 1'b0;
        case (state)
            REQ:       fail = ~clk_fe && (timer == START_LAST);
            DATA:      fail = ~clk_fe && (timer == XFER_LAST);
            ACK:       fail = clk_fe ? dat_s : (timer == XFER_LAST);
            WAIT_IDLE: fail = ~(clk_s & dat_s) && (timer == XFER_LAST);
            default:   fail = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried    <= 1'b0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (fail) begin
                ps2_dat_oe <= 1'b0;
                timer      <= '0;
                if (retry_ok) begin
                    state      <= INHIBIT;
                    ps2_clk_oe <= 1'b1;
`ifdef PS2_TX_RETRY_EN
                    retried    <= 1'b1;
`endif
                end else begin
                    state      <= ERR;
                    ps2_clk_oe <= 1'b0;
                    tx_error   <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            state      <= INHIBIT;
                            frame      <= build_frame(tx_data);
                            timer      <= '0;
                            bit_cnt    <= '0;
                            tx_ready   <= 1'b0;
                            busy       <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                            retried    <= 1'b0;
`endif
                        end
                    end
                    INHIBIT: begin
                        if (timer == INHIBIT_LAST) begin
                            state      <= REQ;
                            timer      <= '0;
                            ps2_clk_oe <= 1'b0;
                            ps2_dat_oe <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    REQ: begin
                        if (clk_fe) begin
                            state      <= DATA;
                            timer      <= '0;
                            bit_cnt    <= 4'd1;
                            ps2_dat_oe <= ~frame[0];
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    DATA: begin
                        timer <= timer + 1'b1;
                        if (clk_fe) begin
                            if (bit_cnt == LAST_INDEX) begin
                                state      <= ACK;
                                ps2_dat_oe <= 1'b0;
                            end else begin
                                ps2_dat_oe <= ~frame[bit_cnt];
                                bit_cnt    <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ACK: begin
                        timer <= timer + 1'b1;
                        if (clk_fe) begin
                            state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        timer <= timer + 1'b1;
                        if (clk_s && dat_s) begin
                            state   <= DONE;
                            tx_done <= 1'b1;
                        end
                    end
                    DONE, ERR: begin
                        state      <= IDLE;
                        tx_ready   <= 1'b1;
                        busy       <= 1'b0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a device BFM on the open-drain bus
module tb_ps2_host_tx;

    localparam int I_C = 40;
    localparam int S_C = 300;
    localparam int X_C = 2000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES       (I_C),
        .START_TIMEOUT_CYCLES (S_C),
        .XFER_TIMEOUT_CYCLES  (X_C),
        .CNT_W                (12)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    typedef struct {
        logic [7:0] data;
        bit         err;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] cap_frame = '0;
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         oe_run = 0;
    int         last_inhibit_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: data LSB first, then a parity bit making the total count of ones odd, then stop=1.
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    always @(negedge clock) begin
        if (ps2_clk_oe) oe_run++;
        else begin
            if (oe_run != 0) last_inhibit_len = oe_run;
            oe_run = 0;
        end
    end

    always @(negedge clock) begin
        if (!reset && (tx_done || tx_error)) begin
            if (tx_done) done_cnt++;
            if (tx_error) err_cnt++;
            check("done_error_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_completion", {31'd0, tx_done}, {31'd0, tx_error});
                check("unexpected_completion_count", 32'd1, 32'd0 + exp_q.size());
            end else begin
                mon_e = exp_q.pop_front();
                check("outcome_is_error", {31'd0, tx_error}, {31'd0, mon_e.err});
                if (tx_done && !mon_e.err)
                    check("frame_bits", {22'd0, cap_frame}, {22'd0, exp_frame(mon_e.data)});
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit push, input bit err);
        int n;
        exp_t e;
        n = 0;
        while (!tx_ready && n < 20000) begin @(negedge clock); n++; end
        check("send_ready", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        if (push) begin
            e.data = d;
            e.err  = err;
            exp_q.push_back(e);
        end
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (!tx_ready && n < 20000) begin @(negedge clock); n++; end
        check("return_to_idle", {31'd0, tx_ready}, 32'd1);
        @(negedge clock);
    endtask

    // Device side: waits for the request-to-send, clocks 12 falling edges, samples host bits on
    // the high phase after edges 1..10 and holds data low across edge 12 when ack is set.
    task automatic device_frame(input int half, input bit ack, input int stop_after);
        int n;
        n = 0;
        while (!(ps2_clk_in && !ps2_dat_in) && n < 20000) begin @(negedge clock); n++; end
        check("bfm_request_seen", {31'd0, n < 20000}, 32'd1);
        repeat (half) @(negedge clock);
        for (int k = 1; k <= 12; k++) begin
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clock);
            if (k == 12) dev_dat_low = 1'b0;
            dev_clk_low = 1'b0;
            if (k == 11 && ack) dev_dat_low = 1'b1;
            repeat (half / 2) @(negedge clock);
            if (k <= 10) cap_frame[k-1] = ps2_dat_in;
            if (k == stop_after) return;
            repeat (half - half / 2) @(negedge clock);
        end
    endtask

    initial begin
        int cnt;
        logic [7:0] d;
        logic [7:0] dir_bytes[6];
        dir_bytes = '{8'h00, 8'h01, 8'hFF, 8'hF4, 8'h80, 8'h7E};

        repeat (3) @(negedge clock);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check("rst_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", {31'd0, tx_ready}, 32'd1);

        // Set-LEDs command with a well-behaved device.
        last_inhibit_len = 0;
        send(8'hED, 1'b1, 1'b0);
        device_frame(20, 1'b1, 0);
        wait_idle();
        check("inhibit_len", last_inhibit_len, I_C);
        check("ed_done_count", done_cnt, 1);
        check("ed_err_count", err_cnt, 0);

        // Parity corners and assorted directed bytes.
        for (int i = 0; i < 6; i++) begin
            send(dir_bytes[i], 1'b1, 1'b0);
            device_frame(16, 1'b1, 0);
            wait_idle();
            if (i == 0) check("parity_00", {31'd0, cap_frame[8]}, 32'd1);
            if (i == 1) check("parity_01", {31'd0, cap_frame[8]}, 32'd0);
            if (i == 2) check("parity_ff", {31'd0, cap_frame[8]}, 32'd1);
        end

        // Randomized bytes and device clock rates.
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            send(d, 1'b1, 1'b0);
            device_frame(int'($urandom_range(12, 30)), 1'b1, 0);
            wait_idle();
        end

        // Device never clocks: start timeout.
        send(8'hA5, 1'b1, 1'b1);
        cnt = 1;
        while (!tx_error && !tx_done && cnt < 5000) begin @(negedge clock); cnt++; end
`ifdef PS2_TX_RETRY_EN
        check("start_timeout_latency", cnt, 2 * (I_C + S_C) + 1);
`else
        check("start_timeout_latency", cnt, I_C + S_C + 1);
`endif
        check("timeout_lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        @(negedge clock);
        check("timeout_ready", {31'd0, tx_ready}, 32'd1);

        // Device NACKs.
`ifdef PS2_TX_RETRY_EN
        send(8'h3C, 1'b1, 1'b0);
        device_frame(18, 1'b0, 0);
        device_frame(18, 1'b1, 0);
`else
        send(8'h3C, 1'b1, 1'b1);
        device_frame(18, 1'b0, 0);
`endif
        wait_idle();

        // Device stalls mid-frame: transfer timeout.
        send(8'h96, 1'b1, 1'b1);
        device_frame(14, 1'b1, 6);
        wait_idle();

        // Reset while driving bit 4 (0xED has bit 4 clear, so data is being pulled low).
        send(8'hED, 1'b0, 1'b0);
        device_frame(20, 1'b1, 5);
        check("mid_frame_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
        #2 reset = 1'b1;
        #1 check("reset_releases_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_ready", {31'd0, tx_ready}, 32'd1);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        send(8'hF4, 1'b1, 1'b0);
        device_frame(20, 1'b1, 0);
        wait_idle();

        // tx_valid while busy is dropped.
        cnt = done_cnt;
        send(8'hC3, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        check("busy_not_ready", {31'd0, tx_ready}, 32'd0);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        device_frame(20, 1'b1, 0);
        wait_idle();
        repeat (50) @(negedge clock);
        check("single_done_while_busy", done_cnt - cnt, 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

endmodule
